// File: rtl/progressive_crossfader.sv
// Two-channel crossfader: a sel-driven FSM ramps a blend weight alpha between
// channel a (alpha=0) and channel b (alpha=2^FRAC_W), feeding a 2-stage blend pipeline.
module progressive_crossfader #(
    parameter int DATA_W     = 11,
    parameter int FRAC_W     = 4,
    parameter int STEP_TICKS = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sample_en,
    input  logic                             sel,
    input  logic signed [DATA_W-1:0]         data_a,
    input  logic signed [DATA_W-1:0]         data_b,
    output logic signed [DATA_W+FRAC_W-1:0]  output_data,
    output logic                             out_valid,
    output logic        [FRAC_W:0]           alpha,
    output logic                             busy
);

    localparam int OUT_W  = DATA_W + FRAC_W;
    localparam int FULL_W = DATA_W + FRAC_W + 3;

    localparam logic [FRAC_W:0] ALPHA_ZERO   = '0;
    localparam logic [FRAC_W:0] ALPHA_ONE    = (FRAC_W+1)'(1);
    localparam logic [FRAC_W:0] ALPHA_MAX    = (FRAC_W+1)'(1 << FRAC_W);
    localparam logic [FRAC_W:0] ALPHA_TOP_M1 = (FRAC_W+1)'((1 << FRAC_W) - 1);
    localparam logic [7:0]      TICK_LAST    = 8'(STEP_TICKS - 1);

    typedef enum logic [1:0] {
        HOLD_A,
        RAMP_UP,
        HOLD_B,
        RAMP_DOWN
    } state_t;

    state_t                    r_state;
    logic [7:0]                r_tick;
    logic [FRAC_W:0]           r_alpha;
    logic                      r_busy;

    logic signed [DATA_W-1:0]  r_s1_a;
    logic signed [DATA_W:0]    r_s1_diff;
    logic        [FRAC_W:0]    r_s1_alpha;
    logic                      r_s1_valid;
    logic signed [OUT_W-1:0]   r_out;
    logic                      r_out_valid;

    logic signed [FULL_W-1:0]  w_a_scaled;
    logic signed [FULL_W-1:0]  w_diff_ext;
    logic signed [FULL_W-1:0]  w_alpha_ext;
    logic signed [FULL_W-1:0]  w_sum;

    // NOTE: state is updated with <= so every branch sees the pre-edge values of r_alpha/r_tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HOLD_A;
            r_tick  <= '0;
            r_alpha <= ALPHA_ZERO;
            r_busy  <= 1'b0;
        end else if (sample_en) begin
            case (r_state)
                HOLD_A: begin
                    if (sel) begin
                        r_state <= RAMP_UP;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                HOLD_B: begin
                    if (!sel) begin
                        r_state <= RAMP_DOWN;
                        r_tick  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!sel) begin
                        r_state <= RAMP_DOWN;
                        r_tick  <= '0;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        // Clamp covers a reversal entered straight from HOLD_B at full scale.
                        if (r_alpha >= ALPHA_TOP_M1) begin
                            r_alpha <= ALPHA_MAX;
                            r_state <= HOLD_B;
                            r_busy  <= 1'b0;
                        end else begin
                            r_alpha <= r_alpha + ALPHA_ONE;
                        end
                    end else begin
                        r_tick <= r_tick + 8'd1;
                    end
                end
                RAMP_DOWN: begin
                    if (sel) begin
                        r_state <= RAMP_UP;
                        r_tick  <= '0;
                    end else if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (r_alpha <= ALPHA_ONE) begin
                            r_alpha <= ALPHA_ZERO;
                            r_state <= HOLD_A;
                            r_busy  <= 1'b0;
                        end else begin
                            r_alpha <= r_alpha - ALPHA_ONE;
                        end
                    end else begin
                        r_tick <= r_tick + 8'd1;
                    end
                end
                default: begin
                    r_state <= HOLD_A;
                    r_tick  <= '0;
                    r_alpha <= ALPHA_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Full-width signed arithmetic; the true blend always lies between a and b, so truncation is exact.
    assign w_a_scaled  = FULL_W'(r_s1_a) <<< FRAC_W;
    assign w_diff_ext  = FULL_W'(r_s1_diff);
    assign w_alpha_ext = FULL_W'({1'b0, r_s1_alpha});
    assign w_sum       = w_a_scaled + w_diff_ext * w_alpha_ext;

    // NOTE: pipeline registers are reset too so output_data reads 0 straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_a      <= '0;
            r_s1_diff   <= '0;
            r_s1_alpha  <= '0;
            r_s1_valid  <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_s1_valid <= sample_en;
            if (sample_en) begin
                r_s1_a     <= data_a;
                r_s1_diff  <= (DATA_W+1)'(data_b) - (DATA_W+1)'(data_a);
                r_s1_alpha <= r_alpha;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= OUT_W'(w_sum);
            end
        end
    end

    assign output_data = r_out;
    assign out_valid   = r_out_valid;
    assign alpha       = r_alpha;
    assign busy        = r_busy;

endmodule

// File: tb/tb_progressive_crossfader.sv
// Bench for progressive_crossfader: STEP_TICKS=1 and STEP_TICKS=3 instances share stimulus and
// are compared every cycle against a behavioural blend model, plus hand-computed spot values.
module tb_progressive_crossfader;

    localparam int DW = 11;
    localparam int FW = 4;
    localparam int FULL = 1 << FW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sample_en = 1'b0;
    logic sel = 1'b0;
    logic signed [DW-1:0] data_a = '0;
    logic signed [DW-1:0] data_b = '0;

    logic signed [DW+FW-1:0] out1, out3;
    logic                    ov1, ov3, busy1, busy3;
    logic [FW:0]             alpha1, alpha3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    progressive_crossfader #(.DATA_W(DW), .FRAC_W(FW), .STEP_TICKS(1)) u_dut1 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .sel(sel),
        .data_a(data_a), .data_b(data_b), .output_data(out1),
        .out_valid(ov1), .alpha(alpha1), .busy(busy1)
    );

    progressive_crossfader #(.DATA_W(DW), .FRAC_W(FW), .STEP_TICKS(3)) u_dut3 (
        .clk(clk), .reset(reset), .sample_en(sample_en), .sel(sel),
        .data_a(data_a), .data_b(data_b), .output_data(out3),
        .out_valid(ov3), .alpha(alpha3), .busy(busy3)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: alpha walks toward the endpoint sel points at, one unit per `step` strobes.
    typedef struct {
        int alpha;
        int dir;   // +1 heading to b, -1 heading to a, 0 settled
        int tick;
    } mstate_t;

    function automatic mstate_t model_step(mstate_t s, bit want_b, int step);
        mstate_t n = s;
        int want = want_b ? 1 : -1;
        if (s.dir == 0) begin
            if ((want_b && s.alpha == 0) || (!want_b && s.alpha == FULL)) begin
                n.dir  = want;
                n.tick = 0;
            end
        end else if (want != s.dir) begin
            n.dir  = want;
            n.tick = 0;
        end else if (s.tick == step - 1) begin
            n.tick  = 0;
            n.alpha = s.alpha + s.dir;
            if (n.alpha > FULL) n.alpha = FULL;
            if (n.alpha < 0)    n.alpha = 0;
            if (n.alpha == FULL || n.alpha == 0) n.dir = 0;
        end else begin
            n.tick = s.tick + 1;
        end
        return n;
    endfunction

    function automatic int blend(int a, int b, int al);
        return a * (FULL - al) + b * al;
    endfunction

    mstate_t m1 = '{0, 0, 0};
    mstate_t m3 = '{0, 0, 0};
    int  p_e1 = 0, p_e3 = 0, q_e1 = 0, q_e3 = 0;
    bit  p_v = 1'b0, q_v = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m1   <= '{0, 0, 0};
            m3   <= '{0, 0, 0};
            p_v  <= 1'b0;
            q_v  <= 1'b0;
            p_e1 <= 0;
            p_e3 <= 0;
            q_e1 <= 0;
            q_e3 <= 0;
        end else begin
            if (sample_en) begin
                m1   <= model_step(m1, sel, 1);
                m3   <= model_step(m3, sel, 3);
                p_e1 <= blend(int'(data_a), int'(data_b), m1.alpha);
                p_e3 <= blend(int'(data_a), int'(data_b), m3.alpha);
            end
            p_v <= sample_en;
            q_v <= p_v;
            if (p_v) begin
                q_e1 <= p_e1;
                q_e3 <= p_e3;
            end
        end
    end

    always @(negedge clk) begin
        check("u1.alpha", alpha1, m1.alpha);
        check("u1.busy", busy1, m1.dir != 0);
        check("u1.out_valid", ov1, q_v);
        check("u1.output_data", out1, q_e1);
        check("u3.alpha", alpha3, m3.alpha);
        check("u3.busy", busy3, m3.dir != 0);
        check("u3.out_valid", ov3, q_v);
        check("u3.output_data", out3, q_e3);
    end

    task automatic drive(input bit en, input bit s, input int a, input int b);
        @(posedge clk);
        #1;
        sample_en = en;
        sel       = s;
        data_a    = DW'(a);
        data_b    = DW'(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sample_en = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.out", out1, 0);
        check("rst.alpha", alpha1, 0);
        check("rst.busy", busy1, 0);
        check("rst.valid", ov1, 0);
        reset = 1'b1;

        // Single strobe holding channel a.
        drive(1, 0, 100, -100);
        idle(2);
        check("single.out", out1, 1600);
        check("single.valid", ov1, 1);
        check("single.alpha", alpha1, 0);
        idle(1);
        check("single.valid_drop", ov1, 0);

        // Continuous ramp up a -> b.
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 100, -100);
            if (k == 7) begin
                check("ramp.out_a4", out1, 800);
                check("ramp.alpha6", alpha1, 6);
                check("ramp.busy", busy1, 1);
            end
            if (k == 11) check("ramp.out_a8", out1, 0);
        end
        idle(2);
        check("ramp.final_out", out1, -1600);
        check("ramp.final_alpha", alpha1, 16);
        check("ramp.final_busy", busy1, 0);
        check("slow.alpha6", alpha3, 6);
        check("slow.busy", busy3, 1);

        // Gaps in sample_en hold the slow ramp.
        drive(1, 1, 100, -100);
        idle(4);
        check("gap.alpha_hold", alpha3, 6);
        drive(1, 1, 100, -100);
        idle(1);
        check("gap.alpha_step", alpha3, 7);

        // Reversal at alpha=7.
        drive(1, 0, 100, -100);
        idle(1);
        check("rev.alpha_kept", alpha3, 7);
        check("rev.busy", busy3, 1);
        check("rev.u1_alpha", alpha1, 16);
        check("rev.u1_busy", busy1, 1);
        repeat (3) drive(1, 0, 100, -100);
        idle(1);
        check("rev.alpha6", alpha3, 6);
        repeat (25) drive(1, 0, 100, -100);
        idle(1);
        check("rev.end_alpha", alpha3, 0);
        check("rev.end_busy", busy3, 0);
        check("rev.u1_end_alpha", alpha1, 0);

        // Full-scale extremes.
        drive(1, 0, -1024, 1023);
        idle(2);
        check("ext.a_only", out1, -16384);
        check("ext.a_only3", out3, -16384);
        repeat (20) drive(1, 1, -1024, 1023);
        idle(2);
        check("ext.b_only", out1, 16368);
        check("ext.alpha16", alpha1, 16);

        // Reset in mid-ramp.
        repeat (8) drive(1, 0, 100, -100);
        idle(1);
        check("mid.alpha9", alpha1, 9);
        check("mid.busy", busy1, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst.out", out1, 0);
        check("arst.valid", ov1, 0);
        check("arst.alpha", alpha1, 0);
        check("arst.busy", busy1, 0);
        check("arst.out3", out3, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1, 0, 100, -100);
        idle(2);
        check("post.out", out1, 1600);
        check("post.valid", ov1, 1);
        check("post.alpha", alpha1, 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/progressive_crossfader.md
PROGRESSIVE_CROSSFADER -- requirements
Module: progressive_crossfader

Interface
REQ-001 SHALL have parameter DATA_W, default 11, input sample width (signed two's complement).
REQ-002 SHALL have parameter FRAC_W, default 4, number of fractional bits of alpha and of output_data.
REQ-003 SHALL have parameter STEP_TICKS, default 1, range 1..255, sample strobes per alpha step.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sample_en, input, 1, one-cycle sample strobe.
REQ-007 SHALL have port sel, input, 1, target channel: 0 = a, 1 = b.
REQ-008 SHALL have port data_a, input, DATA_W, signed channel a sample.
REQ-009 SHALL have port data_b, input, DATA_W, signed channel b sample.
REQ-010 SHALL have port output_data, output, DATA_W+FRAC_W, signed blended sample with FRAC_W fractional bits.
REQ-011 SHALL have port out_valid, output, 1, one-cycle pulse when output_data updates.
REQ-012 SHALL have port alpha, output, FRAC_W+1, unsigned current blend weight, 0 to 2^FRAC_W.
REQ-013 SHALL have port busy, output, 1, high in RAMP_UP or RAMP_DOWN.

Function
REQ-014 SHALL implement FSM states HOLD_A (alpha=0), RAMP_UP, HOLD_B (alpha=2^FRAC_W), RAMP_DOWN.
REQ-015 SHALL evaluate sel, state, tick counter and alpha only on clk edges where sample_en=1; otherwise hold them.
REQ-016 HOLD_A with sel=1 SHALL move to RAMP_UP with tick counter cleared; HOLD_B with sel=0 SHALL move to RAMP_DOWN with tick counter cleared.
REQ-017 In a RAMP state with sel matching the ramp direction, the tick counter SHALL increment per strobe; at STEP_TICKS-1 it SHALL clear and alpha SHALL step by +1 (RAMP_UP) or -1 (RAMP_DOWN).
REQ-018 RAMP_UP SHALL go to HOLD_B on the strobe where alpha becomes 2^FRAC_W; RAMP_DOWN SHALL go to HOLD_A on the strobe where alpha becomes 0.
REQ-019 Reversal (sel=0 in RAMP_UP, sel=1 in RAMP_DOWN) SHALL switch to the opposite RAMP state, clear the tick counter and keep alpha unchanged on that strobe.
REQ-020 alpha SHALL never exceed 2^FRAC_W and never go below 0.
REQ-021 Stage 1: on a sample_en edge SHALL register data_a, diff = data_b - data_a (sign-extended to DATA_W+1 bits, no overflow), and the alpha value present before that edge's update.
REQ-022 Stage 2: on the next edge SHALL register output_data = (a << FRAC_W) + diff * alpha, full-precision signed, truncated to DATA_W+FRAC_W bits (exact, since result lies between a and b).
REQ-023 out_valid SHALL pulse high for one cycle in the cycle after the stage-2 edge; latency from sample_en to output_data/out_valid = 2 clk edges.
REQ-024 alpha=0 SHALL give output_data = data_a << FRAC_W exactly; alpha=2^FRAC_W SHALL give data_b << FRAC_W exactly.
REQ-025 Back-to-back sample_en (every cycle) SHALL be supported at full throughput, one result per strobe.
REQ-026 busy SHALL be a registered decode of state.

Reset
REQ-027 reset=0 SHALL asynchronously force state=HOLD_A, alpha=0, tick counter=0, pipeline registers=0, output_data=0, out_valid=0, busy=0.
REQ-028 Reset mid-ramp SHALL abandon the ramp; after release the first result SHALL use alpha=0.
REQ-029 Release SHALL be synchronous to clk; the first sample_en accepted is on the first edge with reset=1.

Verification (DATA_W=11, FRAC_W=4)
REQ-030 STEP_TICKS=1, sel=0, a=100, b=-100, one strobe -> output_data=1600 two edges later, out_valid one-cycle pulse, alpha=0.
REQ-031 STEP_TICKS=1, sel 0->1, continuous strobes, a=100, b=-100 -> alpha 0,1..16 one step per strobe, busy high during ramp, results follow 1600-200*alpha (alpha=4 -> 800, alpha=8 -> 0), final HOLD_B output=-1600.
REQ-032 STEP_TICKS=3, sel=1 -> alpha increments once every 3 strobes; sample_en gaps hold alpha/counter unchanged.
REQ-033 Reversal at alpha=7 during RAMP_UP -> alpha stays 7 that strobe, then 6,5..0, HOLD_A, busy low.
REQ-034 a=-1024, b=1023, alpha=16 -> output_data=16368; alpha=0 -> -16384; no overflow.
REQ-035 reset asserted at alpha=9 mid-ramp -> all outputs 0 immediately without clk; after release, sel=0 strobe -> result uses alpha=0.
